// File: rtl/seq_detect_param.sv
// Runtime-programmable serial sequence detector: a fill counter plus a shift-register
// comparator with a masked compare, registered match pulse and saturating match counter.
module seq_detect_param #(
  parameter int                 MAX_LEN     = 4,
  parameter int                 COUNT_W     = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PAT = MAX_LEN'(4'b0101),
  parameter logic               DEFAULT_OVL = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         cfg_load,
  input  logic [MAX_LEN-1:0]           cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
  input  logic                         cfg_overlap,
  input  logic                         count_clr,
  output logic                         y,
  output logic [COUNT_W-1:0]           match_count,
  output logic                         count_sat
);

  localparam int               LEN_W    = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] history, history_d, hist_shift, pattern, pattern_d, mask;
  logic [LEN_W-1:0]   fill, fill_d, fill_inc, len, len_d;
  logic               overlap, overlap_d, y_d, hit, count_sat_d;
  logic [COUNT_W-1:0] match_count_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    history_d     = history;
    fill_d        = fill;
    pattern_d     = pattern;
    len_d         = len;
    overlap_d     = overlap;
    y_d           = 1'b0;
    hit           = 1'b0;
    match_count_d = match_count;
    count_sat_d   = count_sat;

    hist_shift = {history[MAX_LEN-2:0], din};
    fill_inc   = (fill >= len) ? len : fill + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = (cfg_len == '0 || cfg_len > FULL_LEN) ? FULL_LEN : cfg_len;
      overlap_d = cfg_overlap;
      history_d = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      hit = (fill_inc == len) && (((hist_shift ^ pattern) & mask) == '0);
      y_d = hit;
      // Non-overlapping mode restarts from an empty window after each match.
      if (hit && !overlap) begin
        history_d = '0;
        fill_d    = '0;
      end else begin
        history_d = hist_shift;
        fill_d    = fill_inc;
      end
    end

    if (count_clr) begin
      match_count_d = '0;
      count_sat_d   = 1'b0;
    end else if (hit) begin
      if (match_count != '1) match_count_d = match_count + 1'b1;
      count_sat_d = count_sat | (match_count_d == '1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      history     <= '0;
      fill        <= '0;
      pattern     <= DEFAULT_PAT;
      len         <= FULL_LEN;
      overlap     <= DEFAULT_OVL;
      y           <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      history     <= history_d;
      fill        <= fill_d;
      pattern     <= pattern_d;
      len         <= len_d;
      overlap     <= overlap_d;
      y           <= y_d;
      match_count <= match_count_d;
      count_sat   <= count_sat_d;
    end
  end

endmodule
